// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants for the rsa_unit sequencer.
//   Register addresses, CTRL/STATUS bit positions, FSM state type and the
//   TMO_LIM reset value.
package rsa_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_P       = 3'd2;
  localparam logic [2:0] ADDR_E       = 3'd3;
  localparam logic [2:0] ADDR_M       = 3'd4;
  localparam logic [2:0] ADDR_CONST   = 3'd5;
  localparam logic [2:0] ADDR_RESULT  = 3'd6;
  localparam logic [2:0] ADDR_TMO_LIM = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TMO  = 2;
  localparam int ST_ERR  = 3;

  localparam logic [7:0] TMO_LIM_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    DONE_ST = 2'd3
  } rsa_state_e;

endpackage

// File: rtl/rsa_seq_regs.sv
// rsa_seq_regs: register file for the rsa_unit sequencer.
//   clk_i, rst_i              clock, async active-high reset
//   reg_wr_i/reg_rd_i         one-cycle write/read strobes
//   reg_addr_i/reg_wdata_i    register address and write data
//   reg_rdata_o               registered read data (1-cycle latency)
//   busy_i                    sequencer not idle
//   set_done_i/set_tmo_i      status set pulses from the sequencer
//   res_we_i/res_i            result capture strobe and data
//   start_o/abort_o           decoded command pulses (start only when idle)
//   p_o/e_o/m_o/const_o       live operand registers
//   tmo_lim_o                 timeout limit (upper byte of the count limit)
//   irq_o                     level interrupt
module rsa_seq_regs
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LIM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reg_wr_i,
  input  logic             reg_rd_i,
  input  logic [2:0]       reg_addr_i,
  input  logic [WIDTH-1:0] reg_wdata_i,
  output logic [WIDTH-1:0] reg_rdata_o,
  input  logic             busy_i,
  input  logic             set_done_i,
  input  logic             set_tmo_i,
  input  logic             res_we_i,
  input  logic [WIDTH-1:0] res_i,
  output logic             start_o,
  output logic             abort_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] e_o,
  output logic [WIDTH-1:0] m_o,
  output logic [WIDTH-1:0] const_o,
  output logic [LIM_W-1:0] tmo_lim_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] p_q, e_q, m_q, const_q, result_q, rdata_q, rd_mux;
  logic [LIM_W-1:0] tmo_lim_q;
  logic             irq_en_q, done_q, tmo_q, err_q;
  logic             ctrl_wr, st_wr, op_wr, start_cmd;

  assign ctrl_wr   = reg_wr_i && (reg_addr_i == ADDR_CTRL);
  assign st_wr     = reg_wr_i && (reg_addr_i == ADDR_STATUS);
  assign op_wr     = reg_wr_i && (reg_addr_i inside {ADDR_P, ADDR_E, ADDR_M, ADDR_CONST});
  // ABORT in the same write suppresses START entirely.
  assign abort_o   = ctrl_wr && reg_wdata_i[CTRL_ABORT];
  assign start_cmd = ctrl_wr && reg_wdata_i[CTRL_START] && !reg_wdata_i[CTRL_ABORT];
  assign start_o   = start_cmd && !busy_i;

  assign p_o         = p_q;
  assign e_o         = e_q;
  assign m_o         = m_q;
  assign const_o     = const_q;
  assign tmo_lim_o   = tmo_lim_q;
  assign reg_rdata_o = rdata_q;
  assign irq_o       = irq_en_q & (done_q | tmo_q);

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      ADDR_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rd_mux[ST_BUSY] = busy_i;
        rd_mux[ST_DONE] = done_q;
        rd_mux[ST_TMO]  = tmo_q;
        rd_mux[ST_ERR]  = err_q;
      end
      ADDR_P:       rd_mux = p_q;
      ADDR_E:       rd_mux = e_q;
      ADDR_M:       rd_mux = m_q;
      ADDR_CONST:   rd_mux = const_q;
      ADDR_RESULT:  rd_mux = result_q;
      ADDR_TMO_LIM: rd_mux = WIDTH'(tmo_lim_q);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q       <= '0;
      e_q       <= '0;
      m_q       <= '0;
      const_q   <= '0;
      result_q  <= '0;
      rdata_q   <= '0;
      tmo_lim_q <= LIM_W'(TMO_LIM_RST);
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= reg_wdata_i[CTRL_IRQ_EN];
      if (reg_wr_i) begin
        case (reg_addr_i)
          ADDR_P:       p_q       <= reg_wdata_i;
          ADDR_E:       e_q       <= reg_wdata_i;
          ADDR_M:       m_q       <= reg_wdata_i;
          ADDR_CONST:   const_q   <= reg_wdata_i;
          ADDR_TMO_LIM: tmo_lim_q <= reg_wdata_i[LIM_W-1:0];
          default: ;
        endcase
      end
      if (res_we_i) result_q <= res_i;
      // Hardware set has priority over write-1-to-clear.
      if (set_done_i) done_q <= 1'b1;
      else if (start_o || (st_wr && reg_wdata_i[ST_DONE])) done_q <= 1'b0;
      if (set_tmo_i) tmo_q <= 1'b1;
      else if (start_o || (st_wr && reg_wdata_i[ST_TMO])) tmo_q <= 1'b0;
      if (busy_i && (start_cmd || op_wr)) err_q <= 1'b1;
      else if (st_wr && reg_wdata_i[ST_ERR]) err_q <= 1'b0;
      if (reg_rd_i) rdata_q <= rd_mux;
    end
  end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: launches one rsa_unit operation per START command, holds the
// operands in shadow registers while it runs, and ends on eoc or timeout.
//   clk, rst                       clock, async active-high reset
//   reg_wr/reg_rd/reg_addr/reg_wdata/reg_rdata   register bus
//   rsa_en, rsa_p/e/m/const        rsa_unit enable and shadow operands
//   rsa_eoc, rsa_c                 rsa_unit end-of-conversion and result
//   irq                            level interrupt
//
// state   | meaning
// IDLE    | waiting for START, rsa_en low
// LOAD    | copy operands into shadows, clear timeout counter, rsa_en low
// RUN     | rsa_en high, wait for eoc or timeout
// DONE_ST | one cycle with rsa_en low, then DONE is set
module rsa_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [2:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_const,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_c,
  output logic             irq
);

  localparam int LIM_W = TMO_W - 8;

  rsa_state_e       state_q;
  logic             en_q;
  logic [TMO_W-1:0] cnt_q, limit;
  logic [WIDTH-1:0] sh_p_q, sh_e_q, sh_m_q, sh_c_q;
  logic [WIDTH-1:0] op_p, op_e, op_m, op_c;
  logic [LIM_W-1:0] tmo_lim;
  logic             busy, start, abort, at_lim, res_we, set_tmo, set_done;

  assign busy     = (state_q != IDLE);
  assign limit    = {tmo_lim, 8'h00};
  assign at_lim   = (cnt_q == limit);
  // eoc beats the timeout; ABORT beats both.
  assign res_we   = (state_q == RUN) && !abort && rsa_eoc;
  assign set_tmo  = (state_q == RUN) && !abort && !rsa_eoc && at_lim;
  assign set_done = (state_q == DONE_ST) && !abort;

  assign rsa_en    = en_q;
  assign rsa_p     = sh_p_q;
  assign rsa_e     = sh_e_q;
  assign rsa_m     = sh_m_q;
  assign rsa_const = sh_c_q;

  rsa_seq_regs #(.WIDTH(WIDTH), .LIM_W(LIM_W)) u_regs (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_wr_i    (reg_wr),
    .reg_rd_i    (reg_rd),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .busy_i      (busy),
    .set_done_i  (set_done),
    .set_tmo_i   (set_tmo),
    .res_we_i    (res_we),
    .res_i       (rsa_c),
    .start_o     (start),
    .abort_o     (abort),
    .p_o         (op_p),
    .e_o         (op_e),
    .m_o         (op_m),
    .const_o     (op_c),
    .tmo_lim_o   (tmo_lim),
    .irq_o       (irq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      sh_p_q  <= '0;
      sh_e_q  <= '0;
      sh_m_q  <= '0;
      sh_c_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          en_q <= 1'b0;
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          sh_p_q <= op_p;
          sh_e_q <= op_e;
          sh_m_q <= op_m;
          sh_c_q <= op_c;
          cnt_q  <= '0;
          if (abort) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else begin
            state_q <= RUN;
            en_q    <= 1'b1;
          end
        end
        RUN: begin
          if (abort || rsa_eoc || at_lim) begin
            state_q <= (rsa_eoc && !abort) ? DONE_ST : IDLE;
            en_q    <= 1'b0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + TMO_W'(1);
          end
        end
        DONE_ST: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rsa_seq_ctrl.md
Name: rsa_seq_ctrl

Overview:
Register-mapped sequencer sitting between the SPI slave register bus and the rsa_unit modular-exponentiation datapath. Holds the operand registers P, E, M and CONST, and launches one rsa_unit operation per start command. While the operation runs, it holds the operands stable and watches for eoc or a timeout. It then captures C into a result register and raises status and interrupt flags.

Parameters:
WIDTH, 8, operand/result width (matches rsa_unit P/E/M/Const/C)
TMO_W, 16, timeout counter width; limit = {TMO_LIM reg, 8'h00}

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
reg_wr  in  1  register write strobe, one cycle
reg_rd  in  1  register read strobe, one cycle
reg_addr  in  3  register address
reg_wdata  in  WIDTH  write data
reg_rdata  out  WIDTH  read data, registered
rsa_en  out  1  rsa_unit enable
rsa_p  out  WIDTH  operand P to rsa_unit
rsa_e  out  WIDTH  operand E
rsa_m  out  WIDTH  operand M
rsa_const  out  WIDTH  Montgomery constant
rsa_eoc  in  1  end of conversion from rsa_unit
rsa_c  in  WIDTH  result from rsa_unit
irq  out  1  level interrupt

Behaviour:
- Reset: all registers and outputs are 0, FSM=IDLE, irq=0. Exception: TMO_LIM resets to 8'hFF.
- Register map:
  - 0 CTRL (W): bit0 START, write-1 pulse; bit1 ABORT, write-1 pulse; bit2 IRQ_EN (R/W).
  - 1 STATUS: bit0 BUSY (RO); bit1 DONE, bit2 TMO, bit3 ERR. Bits 1-3 are write-1-to-clear.
  - 2 P, 3 E, 4 M, 5 CONST: R/W.
  - 6 RESULT: RO.
  - 7 TMO_LIM: R/W.
- Reads: reg_rdata updates on the cycle after reg_rd (1-cycle latency) and holds its value otherwise. Reads have no side effects.
- Writes to a read-only address, or to bits of STATUS outside bits 1-3, have no effect.
- FSM states and transitions:
  - IDLE: rsa_en=0. START moves to LOAD; the same START write also clears DONE and TMO.
  - LOAD: one cycle. P/E/M/CONST are copied into shadow registers that drive rsa_p..rsa_const. rsa_en stays 0, which guarantees rsa_unit sees at least one disabled cycle. Timeout counter is cleared. Next state is RUN.
  - RUN: rsa_en=1, timeout counter increments every cycle.
    - rsa_eoc=1: RESULT <= rsa_c, then DONE_ST.
    - Counter reaches limit: TMO set, then IDLE.
  - DONE_ST: one cycle. rsa_en=0, DONE set. Next state is IDLE.
- rsa_eoc is sampled only in RUN and ignored in all other states.
- BUSY = (state != IDLE).
- Shadow operands are stable from LOAD until the next LOAD.
- Boundary conditions:
  - START while BUSY: ignored, ERR set.
  - Operand-register write while BUSY: the write still lands (shadows are unaffected) and ERR is set.
  - ABORT in LOAD/RUN/DONE_ST: next state is IDLE, rsa_en=0 next cycle, DONE not set, RESULT unchanged.
  - START and ABORT in the same write: ABORT wins; if IDLE, nothing happens.
  - rsa_eoc on the same cycle the counter hits the limit: eoc wins, no TMO.
  - TMO_LIM=0: limit is 0, so the op times out on the first RUN cycle unless eoc is asserted in that cycle.
  - STATUS write-1-to-clear on the same cycle the hardware sets a bit: the set wins.
  - The counter saturates and never wraps.
- irq = IRQ_EN & (DONE | TMO). Combinational from registered flags.
- rst asserted at any point, including mid-RUN: immediate return to the reset state and rsa_en=0.

Decomposition:
- Shared package rsa_pkg holds:
  - Register address constants: ADDR_CTRL..ADDR_TMO_LIM.
  - CTRL/STATUS bit-index constants.
  - FSM state enum: IDLE, LOAD, RUN, DONE_ST.
  - TMO_LIM reset value.
- One sub-module, rsa_seq_regs: the register file plus read mux, with ERR/W1C logic.
- FSM and timeout counter stay in the top-level rsa_seq_ctrl.

Test Plan:
- Reset/readback: assert rst → all regs read 0, except TMO_LIM=0xFF and irq=0. Write P=0x21 and read it back → 0x21 one cycle after reg_rd.
- Normal op: set P=33, E=7, M=5, CONST=0x0C, IRQ_EN=1, then START. Model asserts eoc after 40 RUN cycles with C=0x0E. Expect:
  - rsa_en low exactly 1 cycle after START, then high.
  - RESULT=0x0E, STATUS=0x02, irq=1.
  - W1C of DONE → irq=0.
- Timeout: TMO_LIM=0x01 and the model never asserts eoc → TMO set after 256 RUN cycles, rsa_en=0, BUSY=0, RESULT unchanged.
- Busy protection: START, then write P=0x55 and START again during RUN → ERR=1. rsa_p keeps its old shadow value and the op still completes; afterwards P reads 0x55.
- Abort and simultaneity: ABORT mid-RUN → IDLE next cycle with DONE=0. Separately, eoc on the limit cycle → DONE=1 and TMO=0.
- Async reset mid-RUN: pulse rst between clock edges → rsa_en=0 immediately and state=IDLE.
